// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encoding, register-zero constant, default memory latency
// and the load-use detection helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MEM_LAT_DEF = 1;

  // A load in ID/EX whose destination is read by the instruction in IF/ID.
  // Writes to $zero never create a dependency.
  function automatic logic load_use(
    input logic       memread,
    input logic [4:0] idex_rt,
    input logic [4:0] ifid_rs,
    input logic [4:0] ifid_rt
  );
    return memread && (idex_rt != REG_ZERO) &&
           ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: register fields and
// stage status flowing in, write/flush/bubble controls flowing out.
interface hazard_ctrl_if;

  logic [4:0] ifid_rs_i;
  logic [4:0] ifid_rt_i;
  logic       idex_memread_i;
  logic [4:0] idex_rt_i;
  logic       branch_taken_i;
  logic       exmem_memacc_i;

  logic       pc_write_o;
  logic       ifid_write_o;
  logic       ifid_flush_o;
  logic       idex_write_o;
  logic       idex_bubble_o;
  logic       exmem_write_o;
  logic       memwb_bubble_o;

  // Pipeline datapath side: supplies status, consumes controls.
  modport master (
    output ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, exmem_memacc_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
           idex_bubble_o, exmem_write_o, memwb_bubble_o
  );

  // Hazard controller side.
  modport slave (
    input  ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, exmem_memacc_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
           idex_bubble_o, exmem_write_o, memwb_bubble_o
  );

endinterface

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step by one when enabled unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage MIPS pipeline.
// Mealy control decode from the FSM state and pipeline status: load-use
// stalls, taken-branch flushes and fixed-latency data-memory freezes,
// plus saturating stall/flush performance counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  hazard_ctrl_if.slave     hz,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // The access cycle itself plus wait_cnt+1 MEM_WAIT cycles (the last one
  // releasing) yields exactly MEM_LAT-1 frozen cycles.
  localparam logic       MEM_STALL_EN = (MEM_LAT > 1);
  localparam int         WAIT_INIT    = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
  localparam logic [3:0] WAIT_LOAD    = 4'(WAIT_INIT);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] wait_q;
  logic [3:0] wait_d;
  logic       freeze_s;
  logic       rules_s;
  logic       lu_s;

  assign lu_s = load_use(hz.idex_memread_i, hz.idex_rt_i,
                         hz.ifid_rs_i, hz.ifid_rt_i);

  // Next-state and wait-count logic; selects freeze or hazard-rule mode.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    freeze_s = 1'b0;
    rules_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (MEM_STALL_EN && hz.exmem_memacc_i) begin
          freeze_s = 1'b1;
          wait_d   = WAIT_LOAD;
          state_d  = ST_MEM_WAIT;
        end else begin
          rules_s  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (wait_q != 4'd0) begin
          freeze_s = 1'b1;
          wait_d   = wait_q - 4'd1;
        end else begin
          // Release cycle: the access completes, memacc is not re-examined.
          rules_s  = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = 4'd0;
      end
    endcase
  end

  // Control output decode; reset forces pass-through, freeze beats
  // load-use, and load-use beats a taken branch.
  always_comb begin
    hz.pc_write_o     = 1'b1;
    hz.ifid_write_o   = 1'b1;
    hz.ifid_flush_o   = 1'b0;
    hz.idex_write_o   = 1'b1;
    hz.idex_bubble_o  = 1'b0;
    hz.exmem_write_o  = 1'b1;
    hz.memwb_bubble_o = 1'b0;
    if (rst_i) begin
      hz.pc_write_o = 1'b1;
    end else if (freeze_s) begin
      hz.pc_write_o     = 1'b0;
      hz.ifid_write_o   = 1'b0;
      hz.idex_write_o   = 1'b0;
      hz.exmem_write_o  = 1'b0;
      hz.memwb_bubble_o = 1'b1;
    end else if (rules_s && lu_s) begin
      hz.pc_write_o    = 1'b0;
      hz.ifid_write_o  = 1'b0;
      hz.idex_bubble_o = 1'b1;
    end else if (rules_s && hz.branch_taken_i) begin
      hz.ifid_flush_o = 1'b1;
    end else begin
      hz.pc_write_o = 1'b1;
    end
  end

  // FSM state and memory wait counter, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state_o = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~hz.pc_write_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (hz.ifid_flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Three instances share one stimulus:
// a (MEM_LAT=4, 16-bit counters), b (MEM_LAT=8, 4-bit counters),
// c (MEM_LAT=1, 16-bit counters). Inputs change 1 ns after a rising
// edge; combinational controls are sampled on the falling edge.
module tb_hazard_ctrl;

  // Control vector order: pc_write, ifid_write, ifid_flush, idex_write,
  // idex_bubble, exmem_write, memwb_bubble.
  localparam logic [6:0] PASS_V = 7'b1101010;
  localparam logic [6:0] FRZ_V  = 7'b0000001;
  localparam logic [6:0] LU_V   = 7'b0001110;
  localparam logic [6:0] BR_V   = 7'b1111010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl_if ifa ();
  hazard_ctrl_if ifb ();
  hazard_ctrl_if ifc ();

  logic [1:0]  state_a, state_b, state_c;
  logic [15:0] stall_a, flush_a, stall_c, flush_c;
  logic [3:0]  stall_b, flush_b;
  logic [6:0]  outs_a, outs_b, outs_c;

  assign outs_a = {ifa.pc_write_o, ifa.ifid_write_o, ifa.ifid_flush_o, ifa.idex_write_o,
                   ifa.idex_bubble_o, ifa.exmem_write_o, ifa.memwb_bubble_o};
  assign outs_b = {ifb.pc_write_o, ifb.ifid_write_o, ifb.ifid_flush_o, ifb.idex_write_o,
                   ifb.idex_bubble_o, ifb.exmem_write_o, ifb.memwb_bubble_o};
  assign outs_c = {ifc.pc_write_o, ifc.ifid_write_o, ifc.ifid_flush_o, ifc.idex_write_o,
                   ifc.idex_bubble_o, ifc.exmem_write_o, ifc.memwb_bubble_o};

  hazard_ctrl #(.MEM_LAT(4), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .hz(ifa),
    .state_o(state_a), .stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
  );

  hazard_ctrl #(.MEM_LAT(8), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .hz(ifb),
    .state_o(state_b), .stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
  );

  hazard_ctrl #(.MEM_LAT(1), .CNT_W(16)) dut_c (
    .clk_i(clk), .rst_i(rst), .hz(ifc),
    .state_o(state_c), .stall_cnt_o(stall_c), .flush_cnt_o(flush_c)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                       input logic [4:0] xrt, input logic br, input logic ma);
    ifa.ifid_rs_i = rs; ifa.ifid_rt_i = rt; ifa.idex_memread_i = mr;
    ifa.idex_rt_i = xrt; ifa.branch_taken_i = br; ifa.exmem_memacc_i = ma;
    ifb.ifid_rs_i = rs; ifb.ifid_rt_i = rt; ifb.idex_memread_i = mr;
    ifb.idex_rt_i = xrt; ifb.branch_taken_i = br; ifb.exmem_memacc_i = ma;
    ifc.ifid_rs_i = rs; ifc.ifid_rt_i = rt; ifc.idex_memread_i = mr;
    ifc.idex_rt_i = xrt; ifc.branch_taken_i = br; ifc.exmem_memacc_i = ma;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    drive(5'd8, 5'd2, 1'b1, 5'd8, 1'b1, 1'b1);
    #1;
    total++; if (outs_a !== PASS_V) begin bad++; $display("FAIL reset_outs: got %b exp %b", outs_a, PASS_V); end
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d exp 0", state_a); end
    total++; if (stall_a !== 16'd0) begin bad++; $display("FAIL reset_stall: got %0d exp 0", stall_a); end
    total++; if (flush_a !== 16'd0) begin bad++; $display("FAIL reset_flush: got %0d exp 0", flush_a); end
    @(posedge clk);
    #1 idle();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    @(posedge clk); #1 drive(5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (outs_a !== LU_V) begin bad++; $display("FAIL lu_rs_outs: got %b exp %b", outs_a, LU_V); end
    @(posedge clk); #1;
    total++; if (stall_a !== 16'd1) begin bad++; $display("FAIL lu_rs_stall: got %0d exp 1", stall_a); end
    drive(5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (outs_a !== LU_V) begin bad++; $display("FAIL lu_rt_outs: got %b exp %b", outs_a, LU_V); end
    @(posedge clk); #1;
    total++; if (stall_a !== 16'd2) begin bad++; $display("FAIL lu_rt_stall: got %0d exp 2", stall_a); end
    drive(5'd3, 5'd4, 1'b1, 5'd8, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (outs_a !== PASS_V) begin bad++; $display("FAIL lu_nomatch_outs: got %b exp %b", outs_a, PASS_V); end
  endtask

  task automatic test_reg_zero();
    @(posedge clk); #1 drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (outs_a !== PASS_V) begin bad++; $display("FAIL zero_outs: got %b exp %b", outs_a, PASS_V); end
    @(posedge clk); #1;
    total++; if (stall_a !== 16'd2) begin bad++; $display("FAIL zero_stall: got %0d exp 2", stall_a); end
  endtask

  task automatic test_branch();
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (outs_a !== BR_V) begin bad++; $display("FAIL br_outs: got %b exp %b", outs_a, BR_V); end
    @(posedge clk); #1;
    total++; if (flush_a !== 16'd1) begin bad++; $display("FAIL br_flush: got %0d exp 1", flush_a); end
    drive(5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (outs_a !== LU_V) begin bad++; $display("FAIL br_lu_outs: got %b exp %b", outs_a, LU_V); end
    @(posedge clk); #1;
    total++; if (flush_a !== 16'd1) begin bad++; $display("FAIL br_lu_flush: got %0d exp 1", flush_a); end
    total++; if (stall_a !== 16'd3) begin bad++; $display("FAIL br_lu_stall: got %0d exp 3", stall_a); end
    idle();
  endtask

  // Single access, held memacc across the release cycle, then a
  // back-to-back access in the first RUN cycle after release.
  task automatic test_mem_wait();
    logic [1:0] stim  [9]; // {exmem_memacc, branch_taken}
    logic [6:0] exp_a [9];
    logic [1:0] exp_s [9];
    logic [6:0] exp_c [9];
    stim  = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    exp_a = '{FRZ_V, FRZ_V, FRZ_V, BR_V, FRZ_V, FRZ_V, FRZ_V, PASS_V, PASS_V};
    exp_s = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    exp_c = '{LU_V, PASS_V, PASS_V, BR_V, PASS_V, PASS_V, PASS_V, PASS_V, PASS_V};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == 0) drive(5'd8, 5'd2, 1'b1, 5'd8, stim[i][0], stim[i][1]);
      else        drive(5'd1, 5'd2, 1'b0, 5'd0, stim[i][0], stim[i][1]);
      @(negedge clk);
      total++; if (outs_a !== exp_a[i]) begin bad++; $display("FAIL mem_outs c%0d: got %b exp %b", i + 1, outs_a, exp_a[i]); end
      total++; if (state_a !== exp_s[i]) begin bad++; $display("FAIL mem_state c%0d: got %0d exp %0d", i + 1, state_a, exp_s[i]); end
      total++; if (outs_c !== exp_c[i]) begin bad++; $display("FAIL lat1_outs c%0d: got %b exp %b", i + 1, outs_c, exp_c[i]); end
      total++; if (state_c !== 2'd0) begin bad++; $display("FAIL lat1_state c%0d: got %0d exp 0", i + 1, state_c); end
    end
    @(posedge clk); #1 idle();
    total++; if (stall_a !== 16'd6) begin bad++; $display("FAIL mem_stall: got %0d exp 6", stall_a); end
    total++; if (flush_a !== 16'd1) begin bad++; $display("FAIL mem_flush: got %0d exp 1", flush_a); end
    total++; if (stall_c !== 16'd1) begin bad++; $display("FAIL lat1_stall: got %0d exp 1", stall_c); end
    total++; if (flush_c !== 16'd1) begin bad++; $display("FAIL lat1_flush: got %0d exp 1", flush_c); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    @(posedge clk); #1 drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    total++; if (outs_b !== FRZ_V) begin bad++; $display("FAIL rmw_c1_outs: got %b exp %b", outs_b, FRZ_V); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (state_b !== 2'd1) begin bad++; $display("FAIL rmw_c2_state: got %0d exp 1", state_b); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (outs_b !== FRZ_V) begin bad++; $display("FAIL rmw_c3_outs: got %b exp %b", outs_b, FRZ_V); end
    total++; if (stall_b !== 4'd2) begin bad++; $display("FAIL rmw_c3_stall: got %0d exp 2", stall_b); end
    #2 rst = 1'b1;
    #1;
    total++; if (state_b !== 2'd0) begin bad++; $display("FAIL rmw_async_state: got %0d exp 0", state_b); end
    total++; if (stall_b !== 4'd0) begin bad++; $display("FAIL rmw_async_stall: got %0d exp 0", stall_b); end
    total++; if (outs_b !== PASS_V) begin bad++; $display("FAIL rmw_async_outs: got %b exp %b", outs_b, PASS_V); end
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (outs_b !== PASS_V) begin bad++; $display("FAIL rmw_after_outs c%0d: got %b exp %b", i, outs_b, PASS_V); end
      total++; if (state_b !== 2'd0) begin bad++; $display("FAIL rmw_after_state c%0d: got %0d exp 0", i, state_b); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(posedge clk); #1 drive(5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    total++; if (stall_b !== 4'd14) begin bad++; $display("FAIL sat_14: got %0d exp 14", stall_b); end
    repeat (6) @(posedge clk);
    #1;
    total++; if (stall_b !== 4'd15) begin bad++; $display("FAIL sat_20: got %0d exp 15", stall_b); end
    total++; if (flush_b !== 4'd0) begin bad++; $display("FAIL sat_flush: got %0d exp 0", flush_b); end
    total++; if (stall_a !== 16'd20) begin bad++; $display("FAIL wide_20: got %0d exp 20", stall_a); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_mem_wait();
    test_reset_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
